trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap sequencer between the pipeline and the machine-mode CSR file. It accepts exceptions, pending interrupts and `mret`, and owns the CSR file's single write port. It serialises the trap-entry writes (mepc, mcause, mtval, mstatus) and the `mret` mstatus update, then issues one PC redirect. While idle it grants the write port to pipeline CSR instructions, and it tracks the current privilege level.

## Interface
- Parameters: none. All CSR addresses, masks and cause codes come from the shared CSR package.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `exc_valid` in 1: synchronous exception from the commit stage.
- `exc_cause` in 64: exception cause code.
- `exc_pc` in 64: PC of the faulting instruction.
- `exc_tval` in 64: trap value for the exception.
- `mret_valid` in 1: `mret` at commit.
- `irq_pc` in 64: PC of the next uncommitted instruction, used as mepc for interrupts.
- `csr_mstatus`, `csr_mtvec`, `csr_mepc`, `csr_mip`, `csr_mie` in 64 each: current CSR values, read combinationally.
- `ins_csr_req` in 1: pipeline CSR write request.
- `ins_csr_addr` in 12: pipeline CSR write address.
- `ins_csr_data` in 64: pipeline CSR write data.
- `ins_csr_gnt` out 1: pipeline write accepted this cycle.
- `csr_wen` out 1: CSR write enable.
- `csr_waddr` out 12: CSR write address.
- `csr_wdata` out 64: CSR write data.
- `flush` out 1: one-cycle pulse, pipeline flush.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out 64: redirect target.
- `busy` out 1: high in any state other than IDLE.
- `priv` out 2: current privilege (0 = U, 1 = S, 3 = M).

## Operation
- FSM states: IDLE, EPC, CAUSE, TVAL, STATUS, RSTATUS, REDIR.
- Events are accepted only in IDLE. Priority: exception > interrupt > mret.
  - On acceptance, cause, epc, tval and kind are latched into registers.
  - `flush` pulses in the acceptance cycle.
  - Trap → EPC; mret → RSTATUS.
- Interrupt taken when `(csr_mip & csr_mie & MIP_MASK) != 0` and (`priv` < M or `csr_mstatus.mie`).
  - Selection order: bit 11, 3, 7, 9, 1, 5.
  - mcause = `MCAUSE_INTERRUPT_MASK | bit`; epc = `irq_pc`; tval = 0.
- Trap sequence, one CSR write per state:
  - EPC: write MEPC ← epc with bits [1:0] cleared.
  - CAUSE: write MCAUSE.
  - TVAL: write MTVAL.
  - STATUS: write MSTATUS ← `csr_mstatus` with mpie ← mie, mie ← 0, mpp ← `priv`; the value is ANDed with MSTATUS_MASK, and `priv` ← M on the same edge.
  - REDIR: redirect.
- MRET sequence:
  - RSTATUS: write MSTATUS with mie ← mpie, mpie ← 1, mpp ← U; `priv` ← old mpp.
  - REDIR: redirect_pc = `csr_mepc`.
- Trap redirect_pc = `csr_mtvec & ~64'h3` (direct mode; see Configuration for vectored).
- `exc_valid`, `mret_valid` and interrupts arriving while `busy` are ignored; the pipeline is flushed at that point.
- Write-port arbitration: `ins_csr_gnt = ins_csr_req & IDLE & !event_accepted`.
  - When granted, `csr_w*` carries the `ins_*` fields.
  - The sequencer always wins; a denied request holds until granted.
- `csr_wen` is low in the acceptance cycle and in REDIR.

## Timing
- Reset: state IDLE and `priv` = M (2'b11). All other outputs are 0, including `csr_wdata` and `redirect_pc`.
- Trap accepted in cycle 0:
  - EPC/CAUSE/TVAL/STATUS writes occur in cycles 1–4.
  - `redirect_valid` in cycle 5; back in IDLE in cycle 6, which can accept again.
- mret accepted in cycle 0: RSTATUS write in cycle 1, redirect in cycle 2.
- Each CSR write takes effect at the rising edge that ends its cycle.
- `priv` updates at the end of STATUS or RSTATUS and is stable during REDIR.
- Simultaneous exception + mret: the exception wins and the mret is dropped.
- Simultaneous exception + `ins_csr_req`: the trap is accepted and the grant is denied.
- `rst_n` low mid-sequence: immediate return to IDLE. Partially written CSRs are left as written; the CSR file's own reset governs them.

## Configuration
- `TRAP_VECTORED_EN` defined: when `csr_mtvec[1:0]` == 1 and the trap is an interrupt, redirect_pc = base + 4 × (cause & 63). Exceptions always use base.
- `TRAP_VECTORED_EN` undefined: mtvec mode bits are ignored; every trap goes to base.

## Structure
- Add to the shared CSR package:
  - the FSM state enum `trap_state_t`;
  - privilege constants `PRIV_U`, `PRIV_S`, `PRIV_M`;
  - interrupt bit indices (MEI = 11, MSI = 3, MTI = 7, SEI = 9, SSI = 1, STI = 5).
- Reuse the existing `mstatus_t` cast, CSR address constants, MIP_MASK, MSTATUS_MASK and cause codes.
- One sub-module, `irq_select`: combinational fixed-priority picker from the pending vector to {valid, cause}.

## Test plan
- `priv` = U, `exc_valid` with cause 8 at pc 0x8000_0010, mtvec 0x8000_1000, mstatus.mie = 1 → four writes in order:
  - mepc 0x8000_0010;
  - mcause 8;
  - mtval 0;
  - mstatus with mie = 0, mpie = 1, mpp = 0.
  - Then redirect to 0x8000_1000 in cycle 5; `priv` = 3.
- mret with mstatus.mpp = 0, mpie = 1, mepc 0x8000_0014 → mstatus mie = 1, mpie = 1, mpp = 0; redirect 0x8000_0014 in cycle 2; `priv` = 0.
- mip = mie = 0x88 (MSI + MTI), mstatus.mie = 1, priv M → cause 0x8000_0000_0000_0003; mepc = `irq_pc`. With `TRAP_VECTORED_EN` and mtvec 0x8000_1001 → redirect 0x8000_100C.
- mip = mie = 0x80, priv M, mstatus.mie = 0 → no trap taken; `ins_csr_req` to 0x340 is granted the same cycle.
- `ins_csr_req` held during a trap sequence → gnt = 0 until the cycle after REDIR; then 1, with `csr_waddr` = `ins_csr_addr`.
- `rst_n` dropped in the CAUSE state → IDLE, `priv` = 3, `busy` = 0, no redirect; the next exception runs the full sequence.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared machine-mode CSR package: CSR addresses, masks, cause codes, the mstatus view
// and the trap sequencer state/privilege/interrupt-index definitions.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [63:0] MIP_MASK              = 64'h0000_0000_0000_0AAA;
  localparam logic [63:0] MSTATUS_MASK          = 64'h0000_0000_0000_19AA;
  localparam logic [63:0] MCAUSE_INTERRUPT_MASK = 64'h8000_0000_0000_0000;

  localparam logic [63:0] CAUSE_ILLEGAL_INSTR = 64'd2;
  localparam logic [63:0] CAUSE_BREAKPOINT    = 64'd3;
  localparam logic [63:0] CAUSE_ECALL_U       = 64'd8;
  localparam logic [63:0] CAUSE_ECALL_M       = 64'd11;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int unsigned IRQ_SSI = 1;
  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_STI = 5;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_SEI = 9;
  localparam int unsigned IRQ_MEI = 11;

  typedef struct packed {
    logic [50:0] hi;
    logic [1:0]  mpp;
    logic [1:0]  wpri_10_9;
    logic        spp;
    logic        mpie;
    logic        ube;
    logic        spie;
    logic        wpri_4;
    logic        mie;
    logic        wpri_2;
    logic        sie;
    logic        wpri_0;
  } mstatus_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EPC,
    ST_CAUSE,
    ST_TVAL,
    ST_STATUS,
    ST_RSTATUS,
    ST_REDIR
  } trap_state_t;

endpackage

// File: rtl/trap_ctrl_irq_select.sv
// Fixed-priority interrupt picker: MEI > MSI > MTI > SEI > SSI > STI, yields an mcause value.
module irq_select
  import trap_ctrl_pkg::*;
(
  input  logic [11:0] i_pending,
  output logic        o_valid,
  output logic [63:0] o_cause
);

  logic [5:0] w_idx;
  logic       w_unused;

  assign w_unused = ^{i_pending[10], i_pending[8], i_pending[6],
                      i_pending[4], i_pending[2], i_pending[0]};

  always_comb begin
    o_valid = 1'b1;
    w_idx   = '0;
    if      (i_pending[IRQ_MEI]) w_idx = 6'(IRQ_MEI);
    else if (i_pending[IRQ_MSI]) w_idx = 6'(IRQ_MSI);
    else if (i_pending[IRQ_MTI]) w_idx = 6'(IRQ_MTI);
    else if (i_pending[IRQ_SEI]) w_idx = 6'(IRQ_SEI);
    else if (i_pending[IRQ_SSI]) w_idx = 6'(IRQ_SSI);
    else if (i_pending[IRQ_STI]) w_idx = 6'(IRQ_STI);
    else                         o_valid = 1'b0;
    o_cause = o_valid ? (MCAUSE_INTERRUPT_MASK | {58'd0, w_idx}) : '0;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer owning the CSR write port: serialises trap entry / mret CSR updates,
// issues one redirect, tracks privilege. `TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [63:0] exc_cause,
  input  logic [63:0] exc_pc,
  input  logic [63:0] exc_tval,
  input  logic        mret_valid,
  input  logic [63:0] irq_pc,
  input  logic [63:0] csr_mstatus,
  input  logic [63:0] csr_mtvec,
  input  logic [63:0] csr_mepc,
  input  logic [63:0] csr_mip,
  input  logic [63:0] csr_mie,
  input  logic        ins_csr_req,
  input  logic [11:0] ins_csr_addr,
  input  logic [63:0] ins_csr_data,
  output logic        ins_csr_gnt,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy,
  output logic [1:0]  priv
);

  trap_state_t r_state;
  logic [63:0] r_cause, r_epc, r_tval;
  logic        r_irq, r_mret;
  logic [1:0]  r_priv;

  mstatus_t    w_ms, w_ms_trap, w_ms_ret;
  logic [11:0] w_pending;
  logic        w_irq_valid, w_irq_take, w_idle, w_accept;
  logic [63:0] w_irq_cause, w_tvec_base, w_trap_pc;
  logic        w_unused;

  assign w_unused  = ^{csr_mip[63:12], csr_mie[63:12], csr_mtvec[1:0], r_irq};
  assign w_pending = csr_mip[11:0] & csr_mie[11:0] & MIP_MASK[11:0];

  irq_select u_irq_select (
    .i_pending (w_pending),
    .o_valid   (w_irq_valid),
    .o_cause   (w_irq_cause)
  );

  assign w_ms       = mstatus_t'(csr_mstatus);
  assign w_idle     = (r_state == ST_IDLE);
  assign w_irq_take = w_irq_valid & ((r_priv != PRIV_M) | w_ms.mie);
  assign w_accept   = w_idle & (exc_valid | w_irq_take | mret_valid);

  always_comb begin
    w_ms_trap      = w_ms;
    w_ms_trap.mpie = w_ms.mie;
    w_ms_trap.mie  = 1'b0;
    w_ms_trap.mpp  = r_priv;
    w_ms_ret       = w_ms;
    w_ms_ret.mie   = w_ms.mpie;
    w_ms_ret.mpie  = 1'b1;
    w_ms_ret.mpp   = PRIV_U;
  end

  assign w_tvec_base = csr_mtvec & ~64'h3;
`ifdef TRAP_VECTORED_EN
  assign w_trap_pc = (csr_mtvec[1:0] == 2'b01 && r_irq)
                   ? w_tvec_base + {56'd0, r_cause[5:0], 2'b00}
                   : w_tvec_base;
`else
  assign w_trap_pc = w_tvec_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_priv  <= PRIV_M;
      r_cause <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
      r_irq   <= 1'b0;
      r_mret  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exc_valid) begin
            r_cause <= exc_cause;
            r_epc   <= exc_pc;
            r_tval  <= exc_tval;
            r_irq   <= 1'b0;
            r_mret  <= 1'b0;
            r_state <= ST_EPC;
          end else if (w_irq_take) begin
            r_cause <= w_irq_cause;
            r_epc   <= irq_pc;
            r_tval  <= '0;
            r_irq   <= 1'b1;
            r_mret  <= 1'b0;
            r_state <= ST_EPC;
          end else if (mret_valid) begin
            r_irq   <= 1'b0;
            r_mret  <= 1'b1;
            r_state <= ST_RSTATUS;
          end
        end
        ST_EPC:     r_state <= ST_CAUSE;
        ST_CAUSE:   r_state <= ST_TVAL;
        ST_TVAL:    r_state <= ST_STATUS;
        ST_STATUS: begin
          r_priv  <= PRIV_M;
          r_state <= ST_REDIR;
        end
        ST_RSTATUS: begin
          r_priv  <= w_ms.mpp;
          r_state <= ST_REDIR;
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Grant is decided combinationally so a pipeline write lands in the same IDLE cycle.
  always_comb begin
    ins_csr_gnt    = ins_csr_req & w_idle & ~w_accept;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      ST_IDLE: if (ins_csr_gnt) begin
        csr_wen   = 1'b1;
        csr_waddr = ins_csr_addr;
        csr_wdata = ins_csr_data;
      end
      ST_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {r_epc[63:2], 2'b00};
      end
      ST_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = r_cause;
      end
      ST_TVAL: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = r_tval;
      end
      ST_STATUS: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = 64'(w_ms_trap) & MSTATUS_MASK;
      end
      ST_RSTATUS: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = 64'(w_ms_ret);
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_mret ? csr_mepc : w_trap_pc;
      end
      default: ;
    endcase
  end

  assign flush = w_accept;
  assign busy  = ~w_idle;
  assign priv  = r_priv;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed table-driven bench for trap_ctrl with a hand-written mid-sequence reset case.
module tb_trap_ctrl;

  typedef struct packed {
    logic        gnt;
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        flush;
    logic        rv;
    logic [63:0] rpc;
    logic        busy;
    logic [1:0]  priv;
  } out_t;

  typedef struct {
    logic        exc;
    logic [63:0] cause;
    logic [63:0] pc;
    logic [63:0] tval;
    logic        mret;
    logic [63:0] ms;
    logic [63:0] mtvec;
    logic [63:0] mipmie;
    logic        req;
    out_t        exp;
  } vec_t;

  localparam logic [63:0] TV    = 64'h8000_1000;
  localparam logic [63:0] TVV   = 64'h8000_1001;
`ifdef TRAP_VECTORED_EN
  localparam logic [63:0] IRQ_TARGET = 64'h8000_100C;
`else
  localparam logic [63:0] IRQ_TARGET = 64'h8000_1000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid, mret_valid, ins_csr_req;
  logic [63:0] exc_cause, exc_pc, exc_tval, irq_pc;
  logic [63:0] csr_mstatus, csr_mtvec, csr_mepc, csr_mip, csr_mie;
  logic [11:0] ins_csr_addr;
  logic [63:0] ins_csr_data;
  logic        ins_csr_gnt, csr_wen, flush, redirect_valid, busy;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata, redirect_pc;
  logic [1:0]  priv;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  vec_t        vq[$];
  int unsigned seg_a_end, seg_b_end, seg_c_end;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret_valid     (mret_valid),
    .irq_pc         (irq_pc),
    .csr_mstatus    (csr_mstatus),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .csr_mip        (csr_mip),
    .csr_mie        (csr_mie),
    .ins_csr_req    (ins_csr_req),
    .ins_csr_addr   (ins_csr_addr),
    .ins_csr_data   (ins_csr_data),
    .ins_csr_gnt    (ins_csr_gnt),
    .csr_wen        (csr_wen),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .priv           (priv)
  );

  task automatic add(input logic e, input logic [63:0] c, input logic [63:0] pc,
                     input logic [63:0] tv, input logic m, input logic [63:0] ms,
                     input logic [63:0] mt, input logic [63:0] mm, input logic rq,
                     input logic g, input logic w, input logic [11:0] wa,
                     input logic [63:0] wd, input logic f, input logic rv,
                     input logic [63:0] rpc, input logic b, input logic [1:0] p);
    vec_t v;
    v.exc = e; v.cause = c; v.pc = pc; v.tval = tv; v.mret = m;
    v.ms = ms; v.mtvec = mt; v.mipmie = mm; v.req = rq;
    v.exp = '{gnt: g, wen: w, waddr: wa, wdata: wd, flush: f, rv: rv,
              rpc: rpc, busy: b, priv: p};
    vq.push_back(v);
  endtask

  task automatic drive_idle(input logic [63:0] ms, input logic [63:0] mt);
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret_valid = 1'b0; csr_mstatus = ms; csr_mtvec = mt;
    csr_mip = '0; csr_mie = '0; ins_csr_req = 1'b0;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = '{gnt: ins_csr_gnt, wen: csr_wen, waddr: csr_waddr, wdata: csr_wdata,
            flush: flush, rv: redirect_valid, rpc: redirect_pc, busy: busy, priv: priv};
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b wen=%b addr=%h data=%h flush=%b rv=%b rpc=%h busy=%b priv=%0d | want gnt=%b wen=%b addr=%h data=%h flush=%b rv=%b rpc=%h busy=%b priv=%0d",
               name, got.gnt, got.wen, got.waddr, got.wdata, got.flush, got.rv, got.rpc,
               got.busy, got.priv, exp.gnt, exp.wen, exp.waddr, exp.wdata, exp.flush,
               exp.rv, exp.rpc, exp.busy, exp.priv);
    end
  endtask

  task automatic run(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i < hi; i++) begin
      @(negedge clk);
      exc_valid   = vq[i].exc;
      exc_cause   = vq[i].cause;
      exc_pc      = vq[i].pc;
      exc_tval    = vq[i].tval;
      mret_valid  = vq[i].mret;
      csr_mstatus = vq[i].ms;
      csr_mtvec   = vq[i].mtvec;
      csr_mip     = vq[i].mipmie;
      csr_mie     = vq[i].mipmie;
      ins_csr_req = vq[i].req;
      #1;
      check($sformatf("row%0d", i), vq[i].exp);
    end
  endtask

  initial begin
    out_t rst_exp;
    irq_pc       = 64'h8000_0023;
    csr_mepc     = 64'h8000_0014;
    ins_csr_addr = 12'h340;
    ins_csr_data = 64'h55;
    rst_exp      = '{gnt: 1'b0, wen: 1'b0, waddr: '0, wdata: '0, flush: 1'b0,
                     rv: 1'b0, rpc: '0, busy: 1'b0, priv: 2'd3};

    // mret to U, then exception from U
    add(0,0,0,0, 1,'h80,TV,0,0,  0,0,'h000,'h0,                1,0,0,            0,3);
    add(0,0,0,0, 0,'h80,TV,0,0,  0,1,'h300,'h88,               0,0,0,            1,3);
    add(0,0,0,0, 0,'h88,TV,0,0,  0,0,'h000,'h0,                0,1,'h8000_0014,  1,0);
    add(0,0,0,0, 0,'h88,TV,0,0,  0,0,'h000,'h0,                0,0,0,            0,0);
    add(1,8,'h8000_0010,0, 0,'h88,TV,0,0, 0,0,'h000,'h0,       1,0,0,            0,0);
    add(0,0,0,0, 0,'h88,TV,0,0,  0,1,'h341,'h8000_0010,        0,0,0,            1,0);
    add(0,0,0,0, 0,'h88,TV,0,0,  0,1,'h342,'h8,                0,0,0,            1,0);
    add(0,0,0,0, 0,'h88,TV,0,0,  0,1,'h343,'h0,                0,0,0,            1,0);
    add(0,0,0,0, 0,'h88,TV,0,0,  0,1,'h300,'h80,               0,0,0,            1,0);
    add(0,0,0,0, 0,'h80,TV,0,0,  0,0,'h000,'h0,                0,1,'h8000_1000,  1,3);
    add(0,0,0,0, 0,'h80,TV,0,0,  0,0,'h000,'h0,                0,0,0,            0,3);
    // interrupt MSI+MTI pending in M with mie=1
    add(0,0,0,0, 0,'h2088,TVV,'h88,0, 0,0,'h000,'h0,           1,0,0,            0,3);
    add(0,0,0,0, 0,'h2088,TVV,'h88,0, 0,1,'h341,'h8000_0020,   0,0,0,            1,3);
    add(0,0,0,0, 0,'h2088,TVV,'h88,0, 0,1,'h342,'h8000_0000_0000_0003, 0,0,0,    1,3);
    add(0,0,0,0, 0,'h2088,TVV,'h88,0, 0,1,'h343,'h0,           0,0,0,            1,3);
    add(0,0,0,0, 0,'h2088,TVV,'h88,0, 0,1,'h300,'h1880,        0,0,0,            1,3);
    add(0,0,0,0, 0,'h1880,TVV,'h88,0, 0,0,'h000,'h0,           0,1,IRQ_TARGET,   1,3);
    // MTI pending but masked by mstatus.mie: pipeline write granted
    add(0,0,0,0, 0,'h1880,TVV,'h80,1, 1,1,'h340,'h55,          0,0,0,            0,3);
    // exception + mret + pipeline request together
    add(1,2,'h8000_0100,'hDEAD, 1,'h1880,TVV,0,1, 0,0,'h000,'h0, 1,0,0,          0,3);
    add(0,0,0,0, 0,'h1880,TVV,0,1, 0,1,'h341,'h8000_0100,      0,0,0,            1,3);
    add(0,0,0,0, 0,'h1880,TVV,0,1, 0,1,'h342,'h2,              0,0,0,            1,3);
    add(0,0,0,0, 0,'h1880,TVV,0,1, 0,1,'h343,'hDEAD,           0,0,0,            1,3);
    add(0,0,0,0, 0,'h1880,TVV,0,1, 0,1,'h300,'h1800,           0,0,0,            1,3);
    add(0,0,0,0, 0,'h1800,TVV,0,1, 0,0,'h000,'h0,              0,1,'h8000_1000,  1,3);
    add(0,0,0,0, 0,'h1800,TVV,0,1, 1,1,'h340,'h55,             0,0,0,            0,3);
    seg_a_end = vq.size();
    // drop to U, then start an exception that reset will cut off
    add(0,0,0,0, 1,'h80,TV,0,0,  0,0,'h000,'h0,                1,0,0,            0,3);
    add(0,0,0,0, 0,'h80,TV,0,0,  0,1,'h300,'h88,               0,0,0,            1,3);
    add(0,0,0,0, 0,'h88,TV,0,0,  0,0,'h000,'h0,                0,1,'h8000_0014,  1,0);
    add(1,5,'h8000_0200,'h44, 0,'h0,TV,0,0, 0,0,'h000,'h0,     1,0,0,            0,0);
    add(0,0,0,0, 0,'h0,TV,0,0,   0,1,'h341,'h8000_0200,        0,0,0,            1,0);
    seg_b_end = vq.size();
    add(1,5,'h8000_0200,'h44, 0,'h0,TV,0,0, 0,0,'h000,'h0,     1,0,0,            0,3);
    add(0,0,0,0, 0,'h0,TV,0,0,   0,1,'h341,'h8000_0200,        0,0,0,            1,3);
    add(0,0,0,0, 0,'h0,TV,0,0,   0,1,'h342,'h5,                0,0,0,            1,3);
    add(0,0,0,0, 0,'h0,TV,0,0,   0,1,'h343,'h44,               0,0,0,            1,3);
    add(0,0,0,0, 0,'h0,TV,0,0,   0,1,'h300,'h1800,             0,0,0,            1,3);
    add(0,0,0,0, 0,'h1800,TV,0,0, 0,0,'h000,'h0,               0,1,'h8000_1000,  1,3);
    add(0,0,0,0, 0,'h1800,TV,0,0, 0,0,'h000,'h0,               0,0,0,            0,3);
    seg_c_end = vq.size();

    rst_n = 1'b0;
    drive_idle('0, TV);
    @(negedge clk); #1;
    check("reset", rst_exp);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, seg_a_end);
    run(seg_a_end, seg_b_end);

    @(negedge clk);
    drive_idle('0, TV);
    #1;
    check("cause_before_reset", '{gnt: 1'b0, wen: 1'b1, waddr: 12'h342, wdata: 64'h5,
                                  flush: 1'b0, rv: 1'b0, rpc: '0, busy: 1'b1, priv: 2'd0});
    rst_n = 1'b0;
    #1;
    check("async_reset", rst_exp);
    @(negedge clk); #1;
    check("held_reset", rst_exp);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("after_reset_idle", rst_exp);

    run(seg_b_end, seg_c_end);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
